// File: rtl/btn_debounce.sv
// btn_debounce
//   Per-channel push-button conditioner. Each raw button bit is brought into
//   the clk domain by a two-flop synchronizer. A level change is accepted
//   only after it has been stable for DEBOUNCE_CYCLES consecutive cycles.
//   The accepted level drives press/release pulses, a long-press pulse and
//   a sticky press flag.
//
// Parameters
//   N_BTN           number of independent button channels
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a change (2..2^20)
//   LONG_CYCLES     cycles a debounced press must persist for long_o (> DEBOUNCE_CYCLES)
//
// Ports
//   clk          single clock, all state on rising edge
//   rst_n        synchronous active-low reset
//   btn_i        raw asynchronous button levels, 1 = pressed
//   btn_o        debounced level
//   press_o      one-cycle pulse per accepted 0->1 change
//   release_o    one-cycle pulse per accepted 1->0 change
//   long_o       one-cycle pulse when a press has persisted LONG_CYCLES
//   event_o      sticky press flag per channel
//   event_clr_i  per-channel clear for event_o, sampled every cycle
module btn_debounce #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] btn_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] long_o,
  output logic [N_BTN-1:0] event_o,
  input  logic [N_BTN-1:0] event_clr_i
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
    $error("btn_debounce: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
  end

  // Long-press counter increment that holds at LONG_MAX, so a press held
  // indefinitely yields exactly one long_o pulse.
  function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] v);
    if (v == LONG_MAX) return v;
    return v + LW'(1);
  endfunction

  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [CW-1:0]    deb_cnt  [N_BTN];
  logic [LW-1:0]    long_cnt [N_BTN];

  logic [N_BTN-1:0] differ;
  logic [N_BTN-1:0] accept;
  logic [LW-1:0]    long_nxt [N_BTN];

  always_comb begin
    differ = '0;
    accept = '0;
    for (int i = 0; i < N_BTN; i++) begin
      long_nxt[i] = '0;
      differ[i]   = s2[i] ^ btn_o[i];
      // The edge that would push the count to DEBOUNCE_CYCLES is the edge
      // that takes the new level, so the counter never wraps.
      accept[i]   = differ[i] && (deb_cnt[i] == DEB_LAST);
      if (btn_o[i]) long_nxt[i] = sat_inc(long_cnt[i]);
    end
  end

  // Stage: synchronizer. s1 feeds only s2; nothing else looks at it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_i;
      s2 <= s1;
    end
  end

  // Stage: debounce, pulse generation, long-press and sticky flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_o     <= '0;
      press_o   <= '0;
      release_o <= '0;
      long_o    <= '0;
      event_o   <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt[i]  <= '0;
        long_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        // Any cycle where s2 agrees with btn_o restarts the count: a single
        // bounce back discards all accumulated credit.
        if (!differ[i] || accept[i]) deb_cnt[i] <= '0;
        else                         deb_cnt[i] <= deb_cnt[i] + CW'(1);

        if (accept[i]) btn_o[i] <= s2[i];
        press_o[i]   <= accept[i] & s2[i];
        release_o[i] <= accept[i] & ~s2[i];

        long_cnt[i] <= long_nxt[i];
        long_o[i]   <= (long_nxt[i] == LONG_MAX) && (long_cnt[i] != LONG_MAX);

        // Set wins over clear both on the edge that raises press_o and on
        // the following edge while press_o is still visible, so a clear
        // issued in reaction to the press pulse cannot swallow that press.
        event_o[i] <= (accept[i] & s2[i]) | press_o[i] | (event_o[i] & ~event_clr_i[i]);
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
module tb_btn_debounce;

  localparam int N = 5;
  localparam int D = 4;
  localparam int L = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_i = '0;
  logic [N-1:0] event_clr_i = '0;
  logic [N-1:0] btn_o, press_o, release_o, long_o, event_o;

  btn_debounce #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_i(btn_i),
    .btn_o(btn_o),
    .press_o(press_o),
    .release_o(release_o),
    .long_o(long_o),
    .event_o(event_o),
    .event_clr_i(event_clr_i)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Reference model: history of raw samples, one per edge. btn_o takes a
  // new level when the D samples that reached s2 before this edge all agree
  // and differ from the current level. Long pulse fires exactly L edges
  // after the rising edge of btn_o if it was still high going into that edge.
  logic [N-1:0] xq[$];
  logic [N-1:0] mb, mpress, mrel, mlong, mev;
  int           rise [N];
  int           ecount = 0;
  bit           armed = 0;

  task automatic model_step();
    logic [N-1:0] v, acc, nlong, nev;
    bit same;
    ecount++;
    if (!rst_n) begin
      xq.delete();
      repeat (D + 2) xq.push_back('0);
      mb = '0; mpress = '0; mrel = '0; mlong = '0; mev = '0;
      for (int i = 0; i < N; i++) rise[i] = -1000000;
      armed = 1;
      return;
    end
    xq.push_back(btn_i);
    while (xq.size() > D + 2) void'(xq.pop_front());
    // xq[0..D-1] are the samples seen on s2 at the last D edges up to this one.
    for (int i = 0; i < N; i++) begin
      same = 1;
      for (int k = 0; k < D; k++) if (xq[k][i] != xq[0][i]) same = 0;
      v[i]     = xq[0][i];
      acc[i]   = same && (v[i] != mb[i]);
      nlong[i] = mb[i] && ((ecount - rise[i]) == L);
      nev[i]   = (acc[i] & v[i]) | mpress[i] | (mev[i] & ~event_clr_i[i]);
    end
    mpress = acc & v;
    mrel   = acc & ~v;
    mlong  = nlong;
    mev    = nev;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        mb[i] = v[i];
        if (v[i]) rise[i] = ecount;
      end
    end
  endtask

  task automatic check5(input string nm, input logic [N-1:0] got, input logic [N-1:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t got=%b exp=%b", nm, $time, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (armed) begin
      check5("model_btn", btn_o, mb);
      check5("model_press", press_o, mpress);
      check5("model_release", release_o, mrel);
      check5("model_long", long_o, mlong);
      check5("model_event", event_o, mev);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn_i = '0;
    event_clr_i = '0;
    tick();
    tick();
    check5("reset_btn", btn_o, '0);
    check5("reset_press", press_o, '0);
    check5("reset_event", event_o, '0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] btn, clr, e_btn, e_press, e_rel, e_long, e_ev;
  } vec_t;

  vec_t tbl [24];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rise, npress, rp, rr;
    logic [N-1:0] lvl, gl;

    // Clean press on channels 0 and 3, clear on 3 around the press pulse,
    // long press after L more edges, then release. Row k = edge k+1.
    for (int k = 1; k <= 24; k++) begin
      tbl[k-1].btn     = (k <= 17) ? 5'b01001 : 5'b00000;
      tbl[k-1].clr     = (k >= 6 && k <= 8) ? 5'b01000 : 5'b00000;
      tbl[k-1].e_btn   = (k >= 6 && k <= 22) ? 5'b01001 : 5'b00000;
      tbl[k-1].e_press = (k == 6) ? 5'b01001 : 5'b00000;
      tbl[k-1].e_rel   = (k == 23) ? 5'b01001 : 5'b00000;
      tbl[k-1].e_long  = (k == 16) ? 5'b01001 : 5'b00000;
      tbl[k-1].e_ev    = (k < 6) ? 5'b00000 : (k < 8) ? 5'b01001 : 5'b00001;
    end

    do_reset();
    for (int k = 0; k < 24; k++) begin
      btn_i = tbl[k].btn;
      event_clr_i = tbl[k].clr;
      tick();
      check5($sformatf("tbl%0d_btn", k + 1), btn_o, tbl[k].e_btn);
      check5($sformatf("tbl%0d_press", k + 1), press_o, tbl[k].e_press);
      check5($sformatf("tbl%0d_release", k + 1), release_o, tbl[k].e_rel);
      check5($sformatf("tbl%0d_long", k + 1), long_o, tbl[k].e_long);
      check5($sformatf("tbl%0d_event", k + 1), event_o, tbl[k].e_ev);
    end
    event_clr_i = '0;

    // Bounce on channel 1: 1,0,1,1,0 then steady 1 -> first accepted at edge 11.
    do_reset();
    first_rise = -1;
    npress = 0;
    for (int k = 1; k <= 20; k++) begin
      btn_i = '0;
      btn_i[1] = (k == 2 || k == 5) ? 1'b0 : 1'b1;
      tick();
      if (btn_o[1] && first_rise < 0) first_rise = k;
      if (press_o[1]) npress++;
    end
    check_int("bounce_first_edge", first_rise, 11);
    check_int("bounce_press_count", npress, 1);

    // Reset mid-operation with all buttons held.
    do_reset();
    btn_i = 5'b11111;
    repeat (9) tick();
    check5("held_btn_before_reset", btn_o, 5'b11111);
    rst_n = 1'b0;
    tick();
    check5("midreset_btn", btn_o, '0);
    check5("midreset_pulses", press_o | release_o | long_o, '0);
    check5("midreset_event", event_o, '0);
    rst_n = 1'b1;
    rp = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (press_o == 5'b11111 && rp < 0) rp = k;
    end
    check_int("repress_after_reset_edge", rp, 6);

    // Simultaneous release of channel 4 and press of channel 0.
    do_reset();
    btn_i = 5'b10000;
    repeat (8) tick();
    btn_i = 5'b00001;
    rp = -1;
    rr = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (press_o[0] && rp < 0) rp = k;
      if (release_o[4] && rr < 0) rr = k;
    end
    check_int("simul_press0_edge", rp, 6);
    check_int("simul_release4_edge", rr, 6);

    // Randomized run against the reference model, with occasional resets.
    do_reset();
    lvl = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(15) == 0) lvl[i] = ~lvl[i];
        gl[i] = ($urandom_range(11) == 0);
      end
      btn_i = lvl ^ gl;
      event_clr_i = N'($urandom) & N'($urandom);
      rst_n = ($urandom_range(299) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
